// File: rtl/axis_mux.sv
// N-to-1 AXI-Stream multiplexer with packet-atomic round-robin arbitration and a registered output stage.
// Optional macro AXIS_MUX_TDEST_EN adds axis_o_tdest carrying the source index of each beat.
module axis_mux #(
  parameter int AXIS_BYTES        = 1,
  parameter int AXIS_TDEST_BITS   = 4,
  parameter int NUM_SLAVE_STREAMS = 2
) (
  input  logic                                      clk,
  input  logic                                      aresetn,
  output logic [NUM_SLAVE_STREAMS-1:0]              axis_i_tready,
  input  logic [NUM_SLAVE_STREAMS-1:0]              axis_i_tvalid,
  input  logic [NUM_SLAVE_STREAMS-1:0]              axis_i_tlast,
  input  logic [NUM_SLAVE_STREAMS*AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                                      axis_o_tready,
  output logic                                      axis_o_tvalid,
  output logic                                      axis_o_tlast,
`ifdef AXIS_MUX_TDEST_EN
  output logic [AXIS_TDEST_BITS-1:0]                axis_o_tdest,
`endif
  output logic [AXIS_BYTES*8-1:0]                   axis_o_tdata
);

  localparam int DATA_W  = AXIS_BYTES * 8;
  localparam int N       = NUM_SLAVE_STREAMS;
  localparam int GRANT_W = $clog2(N);

  if (N < 2 || N > 16 || AXIS_BYTES < 1 || AXIS_TDEST_BITS < GRANT_W) begin : g_bad_params
    $error("axis_mux: illegal parameter combination");
  end

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t               state_q, state_d;
  logic [GRANT_W-1:0]   grant_q, grant_d;
  logic [GRANT_W-1:0]   last_grant_q, last_grant_d;
  logic [GRANT_W-1:0]   rr_pick, rr_cand;
  logic                 rr_found;
  logic                 in_ready, in_fire;

  logic [DATA_W-1:0]    in_data [N];
  logic                 in_last [N];

  for (genvar i = 0; i < N; i++) begin : g_split
    assign in_data[i] = axis_i_tdata[i*DATA_W +: DATA_W];
    assign in_last[i] = axis_i_tlast[i];
  end

  // Round-robin search: first valid input strictly after last_grant, wrapping.
  // NOTE: every always_comb output gets a default on entry so no path leaves it unassigned (no latch).
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_grant_q;
    rr_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      rr_cand = GRANT_W'((int'(last_grant_q) + k) % N);
      if (!rr_found && axis_i_tvalid[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    axis_i_tready = '0;
    in_ready      = 1'b0;
    in_fire       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          grant_d = rr_pick;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        in_ready               = !axis_o_tvalid || axis_o_tready;
        axis_i_tready[grant_q] = in_ready;
        in_fire                = in_ready && axis_i_tvalid[grant_q];
        // A tlast handshake releases the lock; the next cycle is the arbitration gap.
        if (in_fire && in_last[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GRANT_W'(N - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      axis_o_tvalid <= 1'b0;
      axis_o_tlast  <= 1'b0;
      axis_o_tdata  <= '0;
    end else if (in_fire) begin
      axis_o_tvalid <= 1'b1;
      axis_o_tlast  <= in_last[grant_q];
      axis_o_tdata  <= in_data[grant_q];
    end else if (axis_o_tready) begin
      axis_o_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_MUX_TDEST_EN
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      axis_o_tdest <= '0;
    end else if (in_fire) begin
      axis_o_tdest <= AXIS_TDEST_BITS'(grant_q);
    end
  end
`endif

endmodule

// File: tb/tb_axis_mux.sv
// Self-checking bench for axis_mux: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a packet-level arbitration model.
module tb_axis_mux;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int DB = 4;

  logic           clk = 1'b0;
  logic           aresetn = 1'b0;
  logic [N-1:0]   i_tready, i_tvalid, i_tlast;
  logic [N*W-1:0] i_tdata;
  logic           o_tready, o_tvalid, o_tlast;
  logic [W-1:0]   o_tdata;
`ifdef AXIS_MUX_TDEST_EN
  logic [DB-1:0]  o_tdest;
`endif

  always #5 clk = ~clk;

  axis_mux #(
    .AXIS_BYTES(1),
    .AXIS_TDEST_BITS(DB),
    .NUM_SLAVE_STREAMS(N)
  ) dut (
    .clk(clk),
    .aresetn(aresetn),
    .axis_i_tready(i_tready),
    .axis_i_tvalid(i_tvalid),
    .axis_i_tlast(i_tlast),
    .axis_i_tdata(i_tdata),
    .axis_o_tready(o_tready),
    .axis_o_tvalid(o_tvalid),
    .axis_o_tlast(o_tlast),
`ifdef AXIS_MUX_TDEST_EN
    .axis_o_tdest(o_tdest),
`endif
    .axis_o_tdata(o_tdata)
  );

  // Source-side packet state
  logic [7:0] pd [N][16];
  int         plen [N];
  int         pidx [N];
  bit         active [N];
  bit         en [N];

  // Reference model: who owns the output, who was served last, and the output register contents
  int         m_owner, m_last, m_odest;
  bit         m_ov, m_ol;
  logic [7:0] m_od;

  // Observed output handshakes
  logic [7:0] obs_d [$];
  bit         obs_l [$];
  int         obs_s [$];
  int         obs_c [$];

  int tests = 0, fails = 0, cyc = 0, first_v = -1, beats_in = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_ov    = 1'b0;
    m_ol    = 1'b0;
    m_od    = '0;
    m_odest = 0;
  endfunction

  task automatic load(input int i, input int len, input logic [7:0] base, input logic [7:0] stp,
                      input bit rnd);
    for (int k = 0; k < len; k++)
      pd[i][k] = rnd ? 8'($urandom) : 8'(int'(base) + k * int'(stp));
    plen[i]   = len;
    pidx[i]   = 0;
    active[i] = 1'b1;
  endtask

  task automatic clear_obs();
    obs_d.delete();
    obs_l.delete();
    obs_s.delete();
    obs_c.delete();
    first_v = -1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      i_tvalid[i] = active[i] && en[i];
      if (active[i]) begin
        i_tdata[i*W +: W] = pd[i][pidx[i]];
        i_tlast[i]        = (pidx[i] == plen[i] - 1);
      end else begin
        i_tdata[i*W +: W] = 8'($urandom);
        i_tlast[i]        = 1'($urandom);
      end
    end
  endtask

  task automatic compare();
    logic [N-1:0] exp_rdy;
    exp_rdy = '0;
    if (aresetn && m_owner >= 0 && (!m_ov || o_tready)) exp_rdy[m_owner] = 1'b1;
    check("i_tready", 32'(i_tready), 32'(exp_rdy));
    check("o_tvalid", 32'(o_tvalid), 32'(m_ov));
    if (m_ov) begin
      check("o_tdata", 32'(o_tdata), 32'(m_od));
      check("o_tlast", 32'(o_tlast), 32'(m_ol));
`ifdef AXIS_MUX_TDEST_EN
      check("o_tdest", 32'(o_tdest), 32'(m_odest));
`endif
    end
    if (o_tvalid && first_v < 0) first_v = cyc;
    if (o_tvalid && o_tready) begin
      obs_d.push_back(o_tdata);
      obs_l.push_back(o_tlast);
      obs_c.push_back(cyc);
`ifdef AXIS_MUX_TDEST_EN
      obs_s.push_back(int'(o_tdest));
`else
      obs_s.push_back(0);
`endif
    end
  endtask

  // Advance the model by one clock using the inputs that were present at the edge.
  task automatic step();
    int acc;
    acc = -1;
    if (!aresetn) begin
      model_reset();
      cyc++;
      return;
    end
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (i_tvalid[idx]) begin
          m_owner = idx;
          break;
        end
      end
    end else if ((!m_ov || o_tready) && i_tvalid[m_owner]) begin
      acc = m_owner;
    end
    if (acc >= 0) begin
      m_ov    = 1'b1;
      m_od    = i_tdata[acc*W +: W];
      m_ol    = i_tlast[acc];
      m_odest = acc;
      beats_in++;
      if (m_ol) begin
        m_last      = acc;
        m_owner     = -1;
        active[acc] = 1'b0;
      end else begin
        pidx[acc]++;
      end
    end else if (o_tready) begin
      m_ov = 1'b0;
    end
    cyc++;
  endtask

  task automatic cycle();
    drive();
    #1 compare();
    @(posedge clk);
    step();
    @(negedge clk);
  endtask

  function automatic bit busy();
    bit b;
    b = m_ov || (m_owner >= 0);
    for (int i = 0; i < N; i++) b = b || active[i];
    return b;
  endfunction

  task automatic run_until_done(input string name, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      cycle();
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset(input int ncyc);
    aresetn = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      active[i] = 1'b0;
      en[i]     = 1'b0;
    end
    repeat (ncyc) cycle();
    aresetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_a [3];
    logic [7:0] exp_b [8];
    int         off_b [8];
    logic [7:0] exp_d [5];
    int         rem [N];
    int         hold, drop, n;

    exp_a = '{8'h11, 8'h22, 8'h33};
    exp_b = '{8'h00, 8'h01, 8'h40, 8'h41, 8'h04, 8'h05, 8'h44, 8'h45};
    off_b = '{0, 1, 3, 4, 6, 7, 9, 10};
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h50};

    o_tready = 1'b1;
    i_tvalid = '0;
    i_tlast  = '0;
    i_tdata  = '0;
    model_reset();
    @(negedge clk);

    // Reset state
    do_reset(3);
    aresetn = 1'b0;
    drive();
    #1;
    check("rst_tvalid", 32'(o_tvalid), 32'd0);
    check("rst_tlast", 32'(o_tlast), 32'd0);
    check("rst_tdata", 32'(o_tdata), 32'd0);
    check("rst_tready", 32'(i_tready), 32'd0);
`ifdef AXIS_MUX_TDEST_EN
    check("rst_tdest", 32'(o_tdest), 32'd0);
`endif
    @(negedge clk);
    aresetn = 1'b1;

    // A: single 3-beat packet on input 0, latency of two cycles
    clear_obs();
    load(0, 3, 8'h11, 8'h11, 1'b0);
    en[0] = 1'b1;
    n = cyc;
    run_until_done("A_timeout", 20);
    check("A_latency", 32'(first_v - n), 32'd2);
    check("A_count", 32'(obs_d.size()), 32'd3);
    for (int k = 0; k < 3 && k < obs_d.size(); k++) begin
      check("A_data", 32'(obs_d[k]), 32'(exp_a[k]));
      check("A_last", 32'(obs_l[k]), 32'(k == 2));
      check("A_dest", 32'(obs_s[k]), 32'd0);
    end

    // B: both inputs stream 2-beat packets back to back, alternating service
    do_reset(2);
    clear_obs();
    rem = '{2, 2};
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    n = 0;
    while ((busy() || rem[0] > 0 || rem[1] > 0) && n < 60) begin
      for (int i = 0; i < N; i++)
        if (!active[i] && rem[i] > 0) begin
          load(i, 2, 8'(i * 64 + (2 - rem[i]) * 4), 8'd1, 1'b0);
          rem[i]--;
        end
      cycle();
      n++;
    end
    check("B_timeout", 32'(n < 60), 32'd1);
    check("B_count", 32'(obs_d.size()), 32'd8);
    for (int k = 0; k < 8 && k < obs_d.size(); k++) begin
      check("B_data", 32'(obs_d[k]), 32'(exp_b[k]));
      check("B_gap", 32'(obs_c[k] - obs_c[0]), 32'(off_b[k]));
      check("B_last", 32'(obs_l[k]), 32'(k % 2));
    end

    // C: output backpressure holds the second beat for three cycles
    do_reset(2);
    clear_obs();
    load(1, 4, 8'hA0, 8'd1, 1'b0);
    en[1] = 1'b1;
    hold  = 0;
    n     = 0;
    while (busy() && n < 30) begin
      if (m_ov && m_od == 8'hA1 && hold < 3) begin
        o_tready = 1'b0;
        hold++;
        #1;
        check("C_hold_valid", 32'(o_tvalid), 32'd1);
        check("C_hold_data", 32'(o_tdata), 32'hA1);
        check("C_hold_rdy", 32'(i_tready[1]), 32'd0);
      end else begin
        o_tready = 1'b1;
      end
      cycle();
      n++;
    end
    o_tready = 1'b1;
    check("C_timeout", 32'(n < 30), 32'd1);
    check("C_held", 32'(hold), 32'd3);
    check("C_count", 32'(obs_d.size()), 32'd4);
    for (int k = 0; k < 4 && k < obs_d.size(); k++)
      check("C_data", 32'(obs_d[k]), 32'(8'hA0 + k));

    // D: granted input stalls mid-packet; the other input waits for its tlast
    do_reset(2);
    clear_obs();
    load(0, 4, 8'h10, 8'd1, 1'b0);
    load(1, 1, 8'h50, 8'd1, 1'b0);
    en[0] = 1'b1;
    en[1] = 1'b1;
    drop  = 0;
    n     = 0;
    while (busy() && n < 40) begin
      if (active[0] && pidx[0] == 1 && drop < 3) begin
        en[0] = 1'b0;
        drop++;
      end else begin
        en[0] = 1'b1;
      end
      cycle();
      n++;
    end
    check("D_timeout", 32'(n < 40), 32'd1);
    check("D_count", 32'(obs_d.size()), 32'd5);
    for (int k = 0; k < 5 && k < obs_d.size(); k++)
      check("D_order", 32'(obs_d[k]), 32'(exp_d[k]));

    // E: reset mid-packet, then a fresh packet from input 1
    do_reset(2);
    load(0, 4, 8'h20, 8'd1, 1'b0);
    en[0] = 1'b1;
    n = 0;
    while (pidx[0] < 2 && n < 20) begin
      cycle();
      n++;
    end
    check("E_pre_timeout", 32'(n < 20), 32'd1);
    aresetn = 1'b0;
    model_reset();
    active[0] = 1'b0;
    en[0]     = 1'b0;
    drive();
    #1;
    check("E_rst_tvalid", 32'(o_tvalid), 32'd0);
    check("E_rst_tlast", 32'(o_tlast), 32'd0);
    check("E_rst_tdata", 32'(o_tdata), 32'd0);
    check("E_rst_tready", 32'(i_tready), 32'd0);
`ifdef AXIS_MUX_TDEST_EN
    check("E_rst_tdest", 32'(o_tdest), 32'd0);
`endif
    repeat (2) cycle();
    aresetn = 1'b1;
    clear_obs();
    load(1, 3, 8'hC0, 8'd1, 1'b0);
    en[1] = 1'b1;
    run_until_done("E_timeout", 20);
    check("E_count", 32'(obs_d.size()), 32'd3);
    for (int k = 0; k < 3 && k < obs_d.size(); k++) begin
      check("E_data", 32'(obs_d[k]), 32'(8'hC0 + k));
      check("E_last", 32'(obs_l[k]), 32'(k == 2));
`ifdef AXIS_MUX_TDEST_EN
      check("E_dest", 32'(obs_s[k]), 32'd1);
`endif
    end

    // R: randomized traffic, valid gaps and output backpressure
    do_reset(2);
    clear_obs();
    beats_in = 0;
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (!active[i] && $urandom_range(0, 3) == 0)
          load(i, int'($urandom_range(1, 5)), 8'd0, 8'd0, 1'b1);
        en[i] = ($urandom_range(0, 3) != 0);
      end
      o_tready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    o_tready = 1'b1;
    run_until_done("R_drain_timeout", 200);
    check("R_beats", 32'(obs_d.size()), 32'(beats_in));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_mux.md
AXIS_MUX -- requirements
Module: axis_mux

Interface
REQ-001 Parameter AXIS_BYTES, default 1: bytes per beat; tdata width is AXIS_BYTES*8.
REQ-002 Parameter AXIS_TDEST_BITS, default 4: output tdest width; SHALL be >= clog2(NUM_SLAVE_STREAMS).
REQ-003 Parameter NUM_SLAVE_STREAMS, default 2: number of input streams, range 2..16.
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 aresetn  input  1  asynchronous active-low reset.
REQ-006 axis_i_tready  output  NUM_SLAVE_STREAMS  per-input ready.
REQ-007 axis_i_tvalid  input  NUM_SLAVE_STREAMS  per-input valid.
REQ-008 axis_i_tlast  input  NUM_SLAVE_STREAMS  per-input end of packet.
REQ-009 axis_i_tdata  input  NUM_SLAVE_STREAMS*AXIS_BYTES*8  input i at bits [(i+1)*AXIS_BYTES*8-1 : i*AXIS_BYTES*8].
REQ-010 axis_o_tready  input  1  output ready.
REQ-011 axis_o_tvalid  output  1  output valid, registered.
REQ-012 axis_o_tlast  output  1  output end of packet, registered.
REQ-013 axis_o_tdata  output  AXIS_BYTES*8  output data, registered.
REQ-014 axis_o_tdest  output  AXIS_TDEST_BITS  source index, registered; present only with AXIS_MUX_TDEST_EN.

Function
REQ-015 The block SHALL merge N input streams into one output with packet-atomic round-robin arbitration, the inverse of the tdest switch.
REQ-016 FSM states: IDLE, LOCKED.
REQ-017 IDLE: all axis_i_tready low; if any axis_i_tvalid high, grant the first valid index searching upward (wrapping) from last_grant+1, register grant, go to LOCKED next cycle.
REQ-018 LOCKED: axis_i_tready[grant] = (!axis_o_tvalid || axis_o_tready); every other tready low.
REQ-019 Output register loads the granted beat (tdata, tlast, tdest=grant zero-extended) on each input handshake; axis_o_tvalid clears when output handshakes with no new load.
REQ-020 Accepted beat with tlast=1 in LOCKED: last_grant <= grant and state -> IDLE; the following cycle is an arbitration cycle.
REQ-021 Latency: first beat of a packet appears on axis_o_tvalid 2 cycles after its tvalid is seen in IDLE; sustained throughput is 1 beat/cycle within a packet.
REQ-022 Inter-packet gap is exactly 1 cycle of no input acceptance; output may still drain during it.
REQ-023 Output backpressure: with axis_o_tvalid high and axis_o_tready low, output registers hold stable and no input is accepted.
REQ-024 Granted input dropping tvalid mid-packet: grant is held; no other input served until its tlast beat.
REQ-025 Single-beat packet (tvalid and tlast on first beat) is legal and releases the grant after that beat.
REQ-026 Simultaneous requests: exactly one grant; each requesting input is served within N packets.
REQ-027 Output is never driven from a non-granted input; tdata/tlast of non-granted inputs are ignored.

Reset
REQ-028 While aresetn is low: state=IDLE, axis_o_tvalid=0, axis_o_tlast=0, axis_o_tdata=0, axis_o_tdest=0, grant=0, last_grant=NUM_SLAVE_STREAMS-1 (first search starts at index 0), all axis_i_tready=0.
REQ-029 Reset asserted mid-packet SHALL drop the in-flight packet; after deassertion arbitration restarts from index 0.

Configuration
REQ-030 Macro AXIS_MUX_TDEST_EN defined: axis_o_tdest port exists and carries the source index of each beat.
REQ-031 AXIS_MUX_TDEST_EN undefined: axis_o_tdest port and its register are absent; all other behaviour is identical.

Verification
REQ-032 N=2, only input 0 sends a 3-beat packet 0x11,0x22,0x33 with axis_o_tready=1 -> output beats 0x11,0x22,0x33, tlast on third, tdest=0, first valid 2 cycles after input tvalid.
REQ-033 Inputs 0 and 1 both hold 2-beat packets continuously after reset -> output order in0,in1,in0,in1, each packet contiguous, 1-cycle gap between packets.
REQ-034 Input 1 sends 4 beats, axis_o_tready low for cycles 2-4 -> output holds beat 2 stable, axis_i_tready[1] low, no data lost or duplicated.
REQ-035 Input 0 mid-packet drops tvalid for 3 cycles while input 1 is valid -> input 1 is not granted until input 0's tlast beat is accepted.
REQ-036 aresetn pulsed low after 2 of 4 beats of input 0 -> all outputs 0 immediately; next packet from input 1 is delivered complete with tdest=1.
